// File: rtl/ctrl_decode_stage_pkg.sv
// Shared types for the pipelined control decoder: opcodes, control-field enums
// and the packed control word carried from D into E.
package ctrl_pkg;

    localparam logic [6:0] OP_R      = 7'd51;
    localparam logic [6:0] OP_LOAD   = 7'd3;
    localparam logic [6:0] OP_ALUI   = 7'd19;
    localparam logic [6:0] OP_STORE  = 7'd35;
    localparam logic [6:0] OP_BRANCH = 7'd99;
    localparam logic [6:0] OP_JALR   = 7'd103;
    localparam logic [6:0] OP_JAL    = 7'd111;
    localparam logic [6:0] OP_LUI    = 7'd55;
    localparam logic [6:0] OP_AUIPC  = 7'd23;

    typedef enum logic [1:0] {
        RES_ALU = 2'd0,
        RES_MEM = 2'd1,
        RES_PC4 = 2'd2
    } result_src_t;

    typedef enum logic [2:0] {
        IMM_I = 3'd0,
        IMM_S = 3'd1,
        IMM_B = 3'd2,
        IMM_J = 3'd3,
        IMM_U = 3'd4
    } imm_src_t;

    typedef enum logic [2:0] {
        ALU_ADD   = 3'd0,
        ALU_SUB   = 3'd1,
        ALU_FUNCT = 3'd2,
        ALU_PASSB = 3'd3
    } alu_op_t;

    typedef enum logic [1:0] {
        FWD_RF = 2'b00,
        FWD_W  = 2'b01,
        FWD_M  = 2'b10
    } fwd_t;

    typedef struct packed {
        logic        reg_write;
        logic        mem_write;
        logic        branch;
        logic        jump;
        logic        jalr;
        logic        alu_src;
        logic        alu_src_a;
        result_src_t result_src;
        imm_src_t    imm_src;
        alu_op_t     alu_op;
        logic [2:0]  funct3;
        logic        funct7b5;
    } ctrl_word_t;

endpackage

// File: rtl/ctrl_decode_stage_if.sv
// D-stage instruction inputs and E-stage control / hazard outputs of the decode stage.
interface ctrl_decode_stage_if #(
    parameter int REG_ADDR_W = 5
);
    logic [31:0]           instr_d;
    logic                  valid_d;
    logic                  pc_src_e;

    logic                  reg_write_e;
    logic                  mem_write_e;
    logic                  branch_e;
    logic                  jump_e;
    logic                  jalr_e;
    logic                  alu_src_e;
    logic                  alu_src_a_e;
    logic [1:0]            result_src_e;
    logic [2:0]            imm_src_e;
    logic [2:0]            alu_op_e;
    logic [2:0]            funct3_e;
    logic                  funct7b5_e;
    logic [REG_ADDR_W-1:0] rs1_e;
    logic [REG_ADDR_W-1:0] rs2_e;
    logic [REG_ADDR_W-1:0] rd_e;
    logic [1:0]            fwd_a_e;
    logic [1:0]            fwd_b_e;
    logic                  stall_f;
    logic                  stall_d;
    logic                  flush_d;
    logic                  flush_e;
    logic                  illegal_e;
    logic [7:0]            illegal_cnt;

    modport master (
        input  instr_d, valid_d, pc_src_e,
        output reg_write_e, mem_write_e, branch_e, jump_e, jalr_e, alu_src_e,
               alu_src_a_e, result_src_e, imm_src_e, alu_op_e, funct3_e,
               funct7b5_e, rs1_e, rs2_e, rd_e, fwd_a_e, fwd_b_e, stall_f,
               stall_d, flush_d, flush_e, illegal_e, illegal_cnt
    );

    modport slave (
        output instr_d, valid_d, pc_src_e,
        input  reg_write_e, mem_write_e, branch_e, jump_e, jalr_e, alu_src_e,
               alu_src_a_e, result_src_e, imm_src_e, alu_op_e, funct3_e,
               funct7b5_e, rs1_e, rs2_e, rd_e, fwd_a_e, fwd_b_e, stall_f,
               stall_d, flush_d, flush_e, illegal_e, illegal_cnt
    );

endinterface

// File: rtl/ctrl_decode_stage_op_decoder.sv
// Combinational main decoder: instruction word to control word, source-register
// usage and an unknown-opcode flag. Unknown opcodes yield an all-zero word.
module op_decoder
    import ctrl_pkg::*;
(
    input  logic [31:0] i_instr,
    output ctrl_word_t  o_ctrl,
    output logic        o_uses_rs1,
    output logic        o_uses_rs2,
    output logic        o_illegal
);

    logic [6:0] w_opcode;
    logic       w_unused_fields;

    assign w_opcode        = i_instr[6:0];
    assign w_unused_fields = ^{i_instr[31], i_instr[29:15], i_instr[11:7]};

    always_comb begin
        o_ctrl     = '0;
        o_uses_rs1 = 1'b0;
        o_uses_rs2 = 1'b0;
        o_illegal  = 1'b0;
        case (w_opcode)
            OP_R: begin
                o_ctrl.reg_write = 1'b1;
                o_ctrl.alu_op    = ALU_FUNCT;
                o_uses_rs1       = 1'b1;
                o_uses_rs2       = 1'b1;
            end
            OP_LOAD: begin
                o_ctrl.reg_write  = 1'b1;
                o_ctrl.alu_src    = 1'b1;
                o_ctrl.result_src = RES_MEM;
                o_uses_rs1        = 1'b1;
            end
            OP_ALUI: begin
                o_ctrl.reg_write = 1'b1;
                o_ctrl.alu_src   = 1'b1;
                o_ctrl.alu_op    = ALU_FUNCT;
                o_uses_rs1       = 1'b1;
            end
            OP_STORE: begin
                o_ctrl.mem_write = 1'b1;
                o_ctrl.alu_src   = 1'b1;
                o_ctrl.imm_src   = IMM_S;
                o_uses_rs1       = 1'b1;
                o_uses_rs2       = 1'b1;
            end
            OP_BRANCH: begin
                o_ctrl.branch  = 1'b1;
                o_ctrl.imm_src = IMM_B;
                o_ctrl.alu_op  = ALU_SUB;
                o_uses_rs1     = 1'b1;
                o_uses_rs2     = 1'b1;
            end
            OP_JALR: begin
                o_ctrl.reg_write  = 1'b1;
                o_ctrl.jump       = 1'b1;
                o_ctrl.jalr       = 1'b1;
                o_ctrl.alu_src    = 1'b1;
                o_ctrl.result_src = RES_PC4;
                o_uses_rs1        = 1'b1;
            end
            OP_JAL: begin
                o_ctrl.reg_write  = 1'b1;
                o_ctrl.jump       = 1'b1;
                o_ctrl.imm_src    = IMM_J;
                o_ctrl.result_src = RES_PC4;
            end
            OP_LUI: begin
                o_ctrl.reg_write = 1'b1;
                o_ctrl.alu_src   = 1'b1;
                o_ctrl.imm_src   = IMM_U;
                o_ctrl.alu_op    = ALU_PASSB;
            end
            OP_AUIPC: begin
                o_ctrl.reg_write = 1'b1;
                o_ctrl.alu_src   = 1'b1;
                o_ctrl.alu_src_a = 1'b1;
                o_ctrl.imm_src   = IMM_U;
            end
            default: o_illegal = 1'b1;
        endcase
        if (!o_illegal) begin
            o_ctrl.funct3   = i_instr[14:12];
            o_ctrl.funct7b5 = i_instr[30];
        end
    end

endmodule

// File: rtl/ctrl_decode_stage.sv
// Pipelined decode stage: D/E control register, M/W destination trackers,
// load-use stall, branch flush and E-stage forwarding. Optional CTRL_ILLEGAL_TRAP_EN.
module ctrl_decode_stage
    import ctrl_pkg::*;
#(
    parameter int REG_ADDR_W = 5,
    parameter int LOAD_LAT   = 1
) (
    input  logic                clk,
    input  logic                rst,
    ctrl_decode_stage_if.master bus
);

    localparam logic LL2 = (LOAD_LAT == 2);

    ctrl_word_t            w_ctrl_d;
    logic                  w_uses_rs1, w_uses_rs2, w_illegal_d, w_dec_ok;
    logic [REG_ADDR_W-1:0] w_rs1_d, w_rs2_d, w_rd_d;
    logic                  w_use1, w_use2, w_ld_e, w_lu, w_flush_e;
    fwd_t                  w_fwd_a, w_fwd_b;

    ctrl_word_t            r_ctrl_e;
    logic [REG_ADDR_W-1:0] r_rs1_e, r_rs2_e, r_rd_e;
    logic [REG_ADDR_W-1:0] r_rd_m, r_rd_w;
    logic                  r_rw_m, r_ld_m, r_rw_w;

    op_decoder u_op_decoder (
        .i_instr    (bus.instr_d),
        .o_ctrl     (w_ctrl_d),
        .o_uses_rs1 (w_uses_rs1),
        .o_uses_rs2 (w_uses_rs2),
        .o_illegal  (w_illegal_d)
    );

    assign w_dec_ok = bus.valid_d & ~w_illegal_d;
    assign w_rs1_d  = bus.instr_d[15 +: REG_ADDR_W];
    assign w_rs2_d  = bus.instr_d[20 +: REG_ADDR_W];
    assign w_rd_d   = bus.instr_d[7 +: REG_ADDR_W];

    // x0 is never a dependency; bubbles and illegal words never raise a hazard
    assign w_use1 = w_dec_ok & w_uses_rs1 & (w_rs1_d != '0);
    assign w_use2 = w_dec_ok & w_uses_rs2 & (w_rs2_d != '0);
    assign w_ld_e = (r_ctrl_e.result_src == RES_MEM);

    assign w_lu = (w_use1 & ((w_ld_e & (r_rd_e == w_rs1_d)) | (LL2 & r_ld_m & (r_rd_m == w_rs1_d))))
                | (w_use2 & ((w_ld_e & (r_rd_e == w_rs2_d)) | (LL2 & r_ld_m & (r_rd_m == w_rs2_d))));

    assign w_flush_e   = bus.pc_src_e | w_lu;
    assign bus.stall_f = w_lu & ~bus.pc_src_e;
    assign bus.stall_d = w_lu & ~bus.pc_src_e;
    assign bus.flush_d = bus.pc_src_e;
    assign bus.flush_e = w_flush_e;

    always_ff @(posedge clk) begin
        if (rst || w_flush_e || !w_dec_ok) begin
            r_ctrl_e <= '0;
            r_rs1_e  <= '0;
            r_rs2_e  <= '0;
            r_rd_e   <= '0;
        end else begin
            r_ctrl_e <= w_ctrl_d;
            r_rs1_e  <= w_rs1_d;
            r_rs2_e  <= w_rs2_d;
            r_rd_e   <= w_rd_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_m <= '0;
            r_rw_m <= 1'b0;
            r_ld_m <= 1'b0;
            r_rd_w <= '0;
            r_rw_w <= 1'b0;
        end else begin
            r_rd_m <= r_rd_e;
            r_rw_m <= r_ctrl_e.reg_write;
            r_ld_m <= w_ld_e;
            r_rd_w <= r_rd_m;
            r_rw_w <= r_rw_m;
        end
    end

    function automatic fwd_t fwd_sel(input logic [REG_ADDR_W-1:0] rs);
        if (rs != '0 && r_rw_m && r_rd_m == rs)      return FWD_M;
        else if (rs != '0 && r_rw_w && r_rd_w == rs) return FWD_W;
        else                                         return FWD_RF;
    endfunction

    always_comb begin
        w_fwd_a = fwd_sel(r_rs1_e);
        w_fwd_b = fwd_sel(r_rs2_e);
    end

    assign bus.fwd_a_e      = w_fwd_a;
    assign bus.fwd_b_e      = w_fwd_b;
    assign bus.reg_write_e  = r_ctrl_e.reg_write;
    assign bus.mem_write_e  = r_ctrl_e.mem_write;
    assign bus.branch_e     = r_ctrl_e.branch;
    assign bus.jump_e       = r_ctrl_e.jump;
    assign bus.jalr_e       = r_ctrl_e.jalr;
    assign bus.alu_src_e    = r_ctrl_e.alu_src;
    assign bus.alu_src_a_e  = r_ctrl_e.alu_src_a;
    assign bus.result_src_e = r_ctrl_e.result_src;
    assign bus.imm_src_e    = r_ctrl_e.imm_src;
    assign bus.alu_op_e     = r_ctrl_e.alu_op;
    assign bus.funct3_e     = r_ctrl_e.funct3;
    assign bus.funct7b5_e   = r_ctrl_e.funct7b5;
    assign bus.rs1_e        = r_rs1_e;
    assign bus.rs2_e        = r_rs2_e;
    assign bus.rd_e         = r_rd_e;

`ifdef CTRL_ILLEGAL_TRAP_EN
    logic       r_illegal_e;
    logic [7:0] r_illegal_cnt;
    logic       w_illegal_load;

    // only an illegal word that actually enters E is flagged and counted
    assign w_illegal_load = bus.valid_d & w_illegal_d & ~w_flush_e;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_illegal_e   <= 1'b0;
            r_illegal_cnt <= '0;
        end else begin
            r_illegal_e <= w_illegal_load;
            if (w_illegal_load && r_illegal_cnt != 8'hFF)
                r_illegal_cnt <= r_illegal_cnt + 8'd1;
        end
    end

    assign bus.illegal_e   = r_illegal_e;
    assign bus.illegal_cnt = r_illegal_cnt;
`else
    assign bus.illegal_e   = 1'b0;
    assign bus.illegal_cnt = '0;
`endif

endmodule
